// File: rtl/dcache_scope_responder.sv
// Load/store responder backed by a word-addressed store; responses return in order
// LATENCY cycles after acceptance through a stage pipe and a QDEPTH-entry queue.
module dcache_scope_responder #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 256,
    parameter int TAG_W   = 6,
    parameter int LATENCY = 2,
    parameter int QDEPTH  = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_cmd,
    input  logic [1:0]       req_size,
    input  logic             req_signed,
    input  logic [31:0]      req_addr,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [XLEN-1:0]  req_data,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [TAG_W-1:0] resp_tag,
    output logic [XLEN-1:0]  resp_data,
    output logic             resp_has_data,
    output logic             resp_ma
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CW  = $clog2(QDEPTH + 1);
    localparam int QAW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int PW  = TAG_W + XLEN + 2;

    logic [XLEN-1:0]  mem_q [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    logic             req_ready_q, req_ready_d;
    logic             accept_s, pop_s, resp_valid_s;
    logic [AW-1:0]    idx_s;
    logic [1:0]       off_s;
    logic             ma_s, store_s, load_s;
    logic [3:0]       be_s;
    logic [XLEN-1:0]  wdata_s, rdata_s, ldata_s;
    logic [PW-1:0]    resp_pl_s, head_s;
    logic             pipe_vld_s;
    logic [PW-1:0]    pipe_pl_s;
    logic [PW-1:0]    q_pl_q [QDEPTH];
    logic [PW-1:0]    q_pl_d [QDEPTH];
    logic [QAW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    q_cnt_q, q_cnt_d;
    logic             unused_s;

    function automatic logic [XLEN-1:0] load_extract(input logic [XLEN-1:0] word,
                                                     input logic [1:0] off,
                                                     input logic [1:0] size,
                                                     input logic sgn);
        logic [XLEN-1:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    load_extract = sgn ? {{(XLEN-8){sh[7]}}, sh[7:0]}
                                        : {{(XLEN-8){1'b0}}, sh[7:0]};
            2'd1:    load_extract = sgn ? {{(XLEN-16){sh[15]}}, sh[15:0]}
                                        : {{(XLEN-16){1'b0}}, sh[15:0]};
            2'd2:    load_extract = word;
            default: load_extract = {XLEN{1'b0}};
        endcase
    endfunction

    function automatic logic [QAW-1:0] ptr_inc(input logic [QAW-1:0] p);
        if (p == QAW'(QDEPTH - 1)) ptr_inc = {QAW{1'b0}};
        else                       ptr_inc = p + QAW'(1);
    endfunction

    assign unused_s = ^req_addr[31:AW+2];

    // Request decode, alignment check and response payload formation.
    always_comb begin
        accept_s = req_valid & req_ready_q;
        idx_s    = req_addr[AW+1:2];
        off_s    = req_addr[1:0];
        ma_s     = 1'b1;
        be_s     = 4'b0000;
        case (req_size)
            2'd0:    begin ma_s = 1'b0;              be_s = 4'b0001 << off_s; end
            2'd1:    begin ma_s = off_s[0];          be_s = 4'b0011 << off_s; end
            2'd2:    begin ma_s = (off_s != 2'd0);   be_s = 4'b1111;          end
            default: begin ma_s = 1'b1;              be_s = 4'b0000;          end
        endcase
        store_s   = accept_s & req_cmd & ~ma_s;
        load_s    = ~req_cmd & ~ma_s;
        wdata_s   = req_data << {off_s, 3'b000};
        rdata_s   = mem_q[idx_s];
        ldata_s   = load_s ? load_extract(rdata_s, off_s, req_size, req_signed) : {XLEN{1'b0}};
        resp_pl_s = {req_tag, ldata_s, load_s, ma_s};
    end

    // Backing store: byte-lane writes at the accepting edge, deliberately not reset.
    always_ff @(posedge clock) begin
        if (store_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) mem_q[idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
            end
        end
    end

    // Outstanding count spans the stage pipe and the queue, so the queue cannot overflow.
    always_comb begin
        pop_s = resp_valid_s & resp_ready;
        if (accept_s & ~pop_s)      count_d = count_q + CW'(1);
        else if (~accept_s & pop_s) count_d = count_q - CW'(1);
        else                        count_d = count_q;
        req_ready_d = (count_d < CW'(QDEPTH));
    end

    // Outstanding count and ready register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q     <= {CW{1'b0}};
            req_ready_q <= 1'b1;
        end else begin
            count_q     <= count_d;
            req_ready_q <= req_ready_d;
        end
    end

    if (LATENCY > 1) begin : g_pipe
        localparam int NS = LATENCY - 1;
        logic [NS-1:0] stg_vld_q, stg_vld_d;
        logic [PW-1:0] stg_pl_q [NS];
        logic [PW-1:0] stg_pl_d [NS];

        // Shift register carrying responses toward the queue.
        always_comb begin
            stg_vld_d    = {NS{1'b0}};
            stg_vld_d[0] = accept_s;
            stg_pl_d[0]  = resp_pl_s;
            for (int s = 1; s < NS; s++) begin
                stg_vld_d[s] = stg_vld_q[s-1];
                stg_pl_d[s]  = stg_pl_q[s-1];
            end
        end

        // Stage registers.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                stg_vld_q <= {NS{1'b0}};
                for (int s = 0; s < NS; s++) stg_pl_q[s] <= {PW{1'b0}};
            end else begin
                stg_vld_q <= stg_vld_d;
                for (int s = 0; s < NS; s++) stg_pl_q[s] <= stg_pl_d[s];
            end
        end

        assign pipe_vld_s = stg_vld_q[NS-1];
        assign pipe_pl_s  = stg_pl_q[NS-1];
    end else begin : g_nopipe
        assign pipe_vld_s = accept_s;
        assign pipe_pl_s  = resp_pl_s;
    end

    // In-order response queue next state.
    always_comb begin
        q_pl_d = q_pl_q;
        if (pipe_vld_s) begin
            q_pl_d[wr_ptr_q] = pipe_pl_s;
            wr_ptr_d         = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) rd_ptr_d = ptr_inc(rd_ptr_q);
        else       rd_ptr_d = rd_ptr_q;
        if (pipe_vld_s & ~pop_s)      q_cnt_d = q_cnt_q + CW'(1);
        else if (~pipe_vld_s & pop_s) q_cnt_d = q_cnt_q - CW'(1);
        else                          q_cnt_d = q_cnt_q;
    end

    // Response queue registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= {QAW{1'b0}};
            rd_ptr_q <= {QAW{1'b0}};
            q_cnt_q  <= {CW{1'b0}};
            for (int e = 0; e < QDEPTH; e++) q_pl_q[e] <= {PW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            q_cnt_q  <= q_cnt_d;
            for (int e = 0; e < QDEPTH; e++) q_pl_q[e] <= q_pl_d[e];
        end
    end

    // Head fields read as zero whenever nothing is presented.
    always_comb begin
        resp_valid_s = (q_cnt_q != {CW{1'b0}});
        if (resp_valid_s) head_s = q_pl_q[rd_ptr_q];
        else              head_s = {PW{1'b0}};
    end

    assign req_ready = req_ready_q;
    assign resp_valid = resp_valid_s;
    assign {resp_tag, resp_data, resp_has_data, resp_ma} = head_s;

endmodule

// File: tb/tb_dcache_scope_responder.sv
// Directed self-checking bench for dcache_scope_responder (default parameters).
module tb_dcache_scope_responder;
    localparam int LAT = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_cmd = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [5:0]  req_tag = 6'd0;
    logic [31:0] req_data = 32'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [5:0]  resp_tag;
    logic [31:0] resp_data;
    logic        resp_has_data;
    logic        resp_ma;

    int n_chk = 0;
    int n_pass = 0;

    dcache_scope_responder dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_tag(req_tag), .req_data(req_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_tag(resp_tag), .resp_data(resp_data),
        .resp_has_data(resp_has_data), .resp_ma(resp_ma)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic cmd, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [5:0] tag, input logic [31:0] data);
        req_valid  = 1'b1;
        req_cmd    = cmd;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_tag    = tag;
        req_data   = data;
    endtask

    // One request with resp_ready high: checks latency and every response field.
    task automatic single(input string name, input logic cmd, input logic [1:0] size,
                          input logic sgn, input logic [31:0] addr, input logic [5:0] tag,
                          input logic [31:0] data, input logic [31:0] exp_data,
                          input logic exp_hd, input logic exp_ma);
        int k;
        drive(cmd, size, sgn, addr, tag, data);
        check({name, "_rdy"}, req_ready, 32'd1);
        step();
        req_valid = 1'b0;
        k = 1;
        while (resp_valid !== 1'b1 && k < 12) begin
            step();
            k++;
        end
        check({name, "_lat"}, k, LAT);
        check({name, "_tag"}, resp_tag, tag);
        check({name, "_data"}, resp_data, exp_data);
        check({name, "_hd"}, resp_has_data, exp_hd);
        check({name, "_ma"}, resp_ma, exp_ma);
        step();
    endtask

    initial begin
        int seen;
        step();
        step();
        check("rst_vld", resp_valid, 32'd0);
        check("rst_tag", resp_tag, 32'd0);
        check("rst_data", resp_data, 32'd0);
        check("rst_hd_ma", {resp_has_data, resp_ma}, 32'd0);
        reset = 1'b0;
        step();
        check("rel_rdy", req_ready, 32'd1);
        check("rel_vld", resp_valid, 32'd0);

        // store then load of the same word on consecutive cycles
        resp_ready = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 32'h40, 6'd1, 32'hDEADBEEF);
        step();
        drive(1'b0, 2'd2, 1'b0, 32'h40, 6'd2, 32'h0);
        check("b2b_n1_vld", resp_valid, 32'd0);
        check("b2b_n1_rdy", req_ready, 32'd1);
        step();
        req_valid = 1'b0;
        check("b2b_n2_vld", resp_valid, 32'd1);
        check("b2b_n2_tag", resp_tag, 32'd1);
        check("b2b_n2_hd", resp_has_data, 32'd0);
        check("b2b_n2_data", resp_data, 32'd0);
        check("b2b_n2_ma", resp_ma, 32'd0);
        step();
        check("b2b_n3_vld", resp_valid, 32'd1);
        check("b2b_n3_tag", resp_tag, 32'd2);
        check("b2b_n3_data", resp_data, 32'hDEADBEEF);
        check("b2b_n3_hd", resp_has_data, 32'd1);
        step();
        check("b2b_n4_vld", resp_valid, 32'd0);

        // sub-word loads
        single("ldb43s", 1'b0, 2'd0, 1'b1, 32'h43, 6'd3, 32'h0, 32'hFFFFFFDE, 1'b1, 1'b0);
        single("ldb43u", 1'b0, 2'd0, 1'b0, 32'h43, 6'd4, 32'h0, 32'h000000DE, 1'b1, 1'b0);
        single("ldh42s", 1'b0, 2'd1, 1'b1, 32'h42, 6'd5, 32'h0, 32'hFFFFDEAD, 1'b1, 1'b0);
        single("ldh40u", 1'b0, 2'd1, 1'b0, 32'h40, 6'd6, 32'h0, 32'h0000BEEF, 1'b1, 1'b0);

        // misaligned and reserved-size requests
        single("sth41ma", 1'b1, 2'd1, 1'b0, 32'h41, 6'd7, 32'h1234, 32'h0, 1'b0, 1'b1);
        single("ldw40un", 1'b0, 2'd2, 1'b0, 32'h40, 6'd8, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
        single("ldsz3", 1'b0, 2'd3, 1'b0, 32'h40, 6'd9, 32'h0, 32'h0, 1'b0, 1'b1);
        single("ldw42ma", 1'b0, 2'd2, 1'b0, 32'h42, 6'd10, 32'h0, 32'h0, 1'b0, 1'b1);

        // byte/half lane writes
        single("stb41", 1'b1, 2'd0, 1'b0, 32'h41, 6'd11, 32'hFFFFFFAA, 32'h0, 1'b0, 1'b0);
        single("ldw40b", 1'b0, 2'd2, 1'b0, 32'h40, 6'd12, 32'h0, 32'hDEADAAEF, 1'b1, 1'b0);
        single("sth42", 1'b1, 2'd1, 1'b0, 32'h42, 6'd13, 32'h5566, 32'h0, 1'b0, 1'b0);
        single("ldw40h", 1'b0, 2'd2, 1'b0, 32'h40, 6'd14, 32'h0, 32'h5566AAEF, 1'b1, 1'b0);

        // aliasing beyond DEPTH words
        single("stw80", 1'b1, 2'd2, 1'b0, 32'h80, 6'd15, 32'h12345678, 32'h0, 1'b0, 1'b0);
        single("ldalias", 1'b0, 2'd2, 1'b0, 32'h480, 6'd16, 32'h0, 32'h12345678, 1'b1, 1'b0);

        // backpressure: only QDEPTH outstanding
        resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'd2, 1'b0, 32'h80, 6'(10 + i), 32'h0);
            check($sformatf("full_rdy%0d", i), req_ready, (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        req_valid = 1'b0;
        step();
        step();
        check("full_vld", resp_valid, 32'd1);
        check("full_tag", resp_tag, 32'd10);
        check("full_rdy_hold", req_ready, 32'd0);
        resp_ready = 1'b1;
        step();
        check("pop1_rdy", req_ready, 32'd1);
        check("pop1_tag", resp_tag, 32'd11);
        step();
        check("pop2_tag", resp_tag, 32'd12);
        step();
        check("pop3_tag", resp_tag, 32'd13);
        check("pop3_data", resp_data, 32'h12345678);
        step();
        check("drain_vld", resp_valid, 32'd0);
        step();
        step();
        check("no5th_vld", resp_valid, 32'd0);

        // reset mid-flight
        resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 2'd2, 1'b0, 32'h80, 6'(20 + i), 32'h0);
            step();
        end
        req_valid = 1'b0;
        check("mid_pre_vld", resp_valid, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_vld", resp_valid, 32'd0);
        check("mid_rst_tag", resp_tag, 32'd0);
        check("mid_rst_data", resp_data, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check("mid_rel_rdy", req_ready, 32'd1);
        resp_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (resp_valid === 1'b1) seen++;
        end
        check("mid_no_resp", seen, 32'd0);

        // count restarted at zero: exactly four accepts before ready drops
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd2, 1'b0, 32'h80, 6'(40 + i), 32'h0);
            check($sformatf("cnt0_rdy%0d", i), req_ready, 32'd1);
            step();
        end
        req_valid = 1'b0;
        check("cnt0_full", req_ready, 32'd0);
        resp_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        single("post_rst", 1'b0, 2'd2, 1'b0, 32'h80, 6'd30, 32'h0, 32'h12345678, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
